// File: rtl/regfile_dumper_if.sv
// regfile_dumper_if
//   Bundles the two buses the dumper talks to:
//     rd_addr   -> register-file read address (driven by the dumper)
//     rd_data   <- combinational read data for rd_addr
//     out_byte  -> stream byte
//     out_valid -> out_byte is valid
//     out_ready <- sink accepts out_byte when out_valid && out_ready
//   master: the dumper side. slave: register file plus byte sink side.
interface regfile_dumper_if;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output rd_addr,
        output out_byte,
        output out_valid,
        input  rd_data,
        input  out_ready
    );

    modport slave (
        input  rd_addr,
        input  out_byte,
        input  out_valid,
        output rd_data,
        output out_ready
    );
endinterface

// File: rtl/regfile_dumper.sv
// regfile_dumper
//   Debug reader for the CPU register file. A start pulse walks registers
//   FIRST_REG..LAST_REG through a spare read port. Each register is snapshot
//   into a shadow word and sent as a 5-byte frame: {3'b000,index} followed by
//   the four data bytes (MSB first when MSB_FIRST=1, LSB first otherwise).
// Ports
//   clk    in   clock, rising edge
//   clrn   in   asynchronous active-high reset; abandons any dump in progress
//   start  in   dump request, sampled only while idle
//   busy   out  high from the cycle after start is accepted until the done pulse
//   done   out  one-cycle pulse after the last byte is accepted
//   bus    master modport: rd_addr/rd_data read port, out_byte/out_valid/out_ready stream
module regfile_dumper #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    clrn,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    regfile_dumper_if.master        bus
);

    if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
        $error("regfile_dumper: illegal register range FIRST_REG=%0d LAST_REG=%0d",
               FIRST_REG, LAST_REG);
    end

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LATCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
    localparam logic [4:0] LAST_A  = 5'(LAST_REG);

    logic [1:0]  state_q,    state_d;
    logic [4:0]  rd_addr_q,  rd_addr_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic        valid_q,    valid_d;
    logic [7:0]  byte_q,     byte_d;
    logic [2:0]  cnt_q,      cnt_d;
    logic [31:0] shadow_q,   shadow_d;

    // Data byte k (0..3) of the frame, in transmission order.
    function automatic logic [7:0] data_byte(input logic [31:0] w, input logic [2:0] k);
        logic [1:0] sel;
        sel = MSB_FIRST ? ~k[1:0] : k[1:0];
        case (sel)
            2'd0:    data_byte = w[7:0];
            2'd1:    data_byte = w[15:8];
            2'd2:    data_byte = w[23:16];
            default: data_byte = w[31:24];
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        byte_d    = byte_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_addr_d = FIRST_A;
                    busy_d    = 1'b1;
                    state_d   = S_LATCH;
                end
            end
            // rd_addr has been stable for a full cycle, so rd_data is settled.
            S_LATCH: begin
                shadow_d = bus.rd_data;
                byte_d   = {3'b000, rd_addr_q};
                valid_d  = 1'b1;
                cnt_d    = 3'd0;
                state_d  = S_SEND;
            end
            // cnt_q counts data bytes already loaded; the index byte is cnt 0.
            S_SEND: begin
                if (valid_q && bus.out_ready) begin
                    if (cnt_q != 3'd4) begin
                        cnt_d  = cnt_q + 3'd1;
                        byte_d = data_byte(shadow_q, cnt_q);
                    end else begin
                        valid_d = 1'b0;
                        if (rd_addr_q == LAST_A) begin
                            state_d = S_DONE;
                        end else begin
                            rd_addr_d = rd_addr_q + 5'd1;
                            state_d   = S_LATCH;
                        end
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state_q   <= S_IDLE;
            rd_addr_q <= 5'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            byte_q    <= 8'd0;
            cnt_q     <= 3'd0;
            shadow_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            byte_q    <= byte_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.out_byte  = byte_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_regfile_dumper.sv
// tb_regfile_dumper
//   Two dumpers share clk/clrn: u_dut0 dumps r0..r31 MSB first, u_dut1 dumps
//   only r5 LSB first. Each has its own register-file model driving rd_data.
//   Expected bytes are queued when a dump is started and popped on handshakes.
module tb_regfile_dumper;
    logic clk = 1'b0;
    logic clrn = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic busy0, done0, busy1, done1;
    logic [31:0] regs0 [32];
    logic [31:0] regs1 [32];
    logic [7:0]  exp_q [$];
    int n_cmp = 0;
    int n_bad = 0;

    regfile_dumper_if bus0 ();
    regfile_dumper_if bus1 ();

    regfile_dumper #(.FIRST_REG(0), .LAST_REG(31), .MSB_FIRST(1'b1)) u_dut0 (
        .clk(clk), .clrn(clrn), .start(start0), .busy(busy0), .done(done0), .bus(bus0)
    );
    regfile_dumper #(.FIRST_REG(5), .LAST_REG(5), .MSB_FIRST(1'b0)) u_dut1 (
        .clk(clk), .clrn(clrn), .start(start1), .busy(busy1), .done(done1), .bus(bus1)
    );

    always #5 clk = ~clk;

    // Register 0 is hardwired to zero in the CPU register file.
    assign bus0.rd_data = (bus0.rd_addr == 5'd0) ? 32'd0 : regs0[bus0.rd_addr];
    assign bus1.rd_data = (bus1.rd_addr == 5'd0) ? 32'd0 : regs1[bus1.rd_addr];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic preload0();
        logic [7:0] b;
        for (int i = 0; i < 32; i++) begin
            b = 8'(i);
            regs0[i] = {b, ~b, 8'h3C, b ^ 8'h5A};
        end
        regs0[0]  = 32'hFFFFFFFF;
        regs0[1]  = 32'h12345678;
        regs0[31] = 32'hDEADBEEF;
    endtask

    // Expected MSB-first stream for a full r0..r31 dump of regs0.
    task automatic push_dump0();
        logic [31:0] w;
        for (int r = 0; r < 32; r++) begin
            w = (r == 0) ? 32'd0 : regs0[r];
            exp_q.push_back(8'(r));
            exp_q.push_back(w[31:24]);
            exp_q.push_back(w[23:16]);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
    endtask

    // Pulses start0, then consumes the stream with out_ready high pct% of cycles.
    // t4 plants regfile writes during frame 2; abort_at>=0 returns once that many
    // bytes were accepted, leaving the next byte presented.
    task automatic run_dump0(input int pct, input bit t4, input int abort_at,
                             output int dones, output int accepted);
        logic prev_stall, prev_busy, finished;
        logic [7:0] prev_byte, exp_b;
        dones = 0; accepted = 0; prev_stall = 1'b0; prev_busy = 1'b0;
        prev_byte = 8'd0; finished = 1'b0;
        @(posedge clk); #1;
        start0 = 1'b1;
        bus0.out_ready = ($urandom_range(99) < pct);
        @(posedge clk); #1;
        start0 = 1'b0;
        bus0.out_ready = ($urandom_range(99) < pct);
        for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                n_cmp++;
                if (bus0.out_byte !== prev_byte) begin
                    n_bad++;
                    $display("FAIL stall_hold: out_byte %h, required %h", bus0.out_byte, prev_byte);
                end
            end
            if (done0) begin
                dones++;
                n_cmp++;
                if (busy0 !== 1'b0 || prev_busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL busy_at_done: busy %b (prev %b), required 0 (prev 1)", busy0, prev_busy);
                end
                finished = 1'b1;
            end
            if (bus0.out_valid && bus0.out_ready) begin
                n_cmp++;
                accepted++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra_byte: got %h, none expected", bus0.out_byte);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (bus0.out_byte !== exp_b) begin
                        n_bad++;
                        $display("FAIL stream_byte[%0d]: got %h, required %h", accepted - 1, bus0.out_byte, exp_b);
                    end
                end
                if (t4 && bus0.rd_addr == 5'd2 && accepted == 12) begin
                    regs0[2] = 32'h0BAD0BAD;
                    regs0[3] = 32'hCAFEF00D;
                end
            end
            prev_stall = bus0.out_valid && !bus0.out_ready;
            prev_byte  = bus0.out_byte;
            prev_busy  = busy0;
            @(posedge clk); #1;
            if (abort_at >= 0 && accepted == abort_at) finished = 1'b1;
            bus0.out_ready = ($urandom_range(99) < pct);
        end
        if (!finished) begin
            n_cmp++; n_bad++;
            $display("FAIL dump_timeout: accepted %0d bytes, dones %0d", accepted, dones);
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        #1 clrn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy0, done0, bus0.out_valid, bus0.out_byte, bus0.rd_addr} !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_dut0: busy/done/valid/byte/addr = %h, required 0000",
                     {busy0, done0, bus0.out_valid, bus0.out_byte, bus0.rd_addr});
        end
        n_cmp++;
        if ({busy1, done1, bus1.out_valid, bus1.out_byte, bus1.rd_addr} !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_dut1: busy/done/valid/byte/addr = %h, required 0000",
                     {busy1, done1, bus1.out_valid, bus1.out_byte, bus1.rd_addr});
        end
        clrn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy0 !== 1'b0 || bus0.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy %b valid %b, required 0 0", busy0, bus0.out_valid);
        end
    endtask

    task automatic test_full_dump();
        int dones, acc;
        preload0();
        push_dump0();
        run_dump0(100, 1'b0, -1, dones, acc);
        n_cmp++;
        if (dones != 1 || acc != 160 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL full_dump: dones %0d bytes %0d left %0d, required 1 160 0", dones, acc, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_msb_lsb();
        int k, got;
        logic [7:0] exp_b;
        logic seen;
        regs1[5] = 32'hA1B2C3D4;
        exp_q.push_back(8'h05); exp_q.push_back(8'hD4); exp_q.push_back(8'hC3);
        exp_q.push_back(8'hB2); exp_q.push_back(8'hA1);
        bus1.out_ready = 1'b1;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;      // accepted at this edge
        n_cmp++;
        if (bus1.out_valid !== 1'b0 || busy1 !== 1'b1) begin
            n_bad++;
            $display("FAIL lsb_latch_cycle: valid %b busy %b, required 0 1", bus1.out_valid, busy1);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus1.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL lsb_first_valid: valid %b, required 1", bus1.out_valid);
        end
        k = 1; got = 0; seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (done1) begin
                seen = 1'b1;
            end else begin
                if (bus1.out_valid && bus1.out_ready) begin
                    n_cmp++;
                    got++;
                    exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                    if (bus1.out_byte !== exp_b) begin
                        n_bad++;
                        $display("FAIL lsb_byte[%0d]: got %h, required %h", got - 1, bus1.out_byte, exp_b);
                    end
                end
                @(posedge clk);
                k++;
            end
        end
        // 1 LATCH + 5 SEND cycles, then the DONE cycle registers the pulse.
        n_cmp++;
        if (!seen || k != 7 || got != 5) begin
            n_bad++;
            $display("FAIL lsb_done_latency: seen %b edges %0d bytes %0d, required 1 7 5", seen, k, got);
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        int dones, acc;
        preload0();
        push_dump0();
        run_dump0(30, 1'b0, -1, dones, acc);
        n_cmp++;
        if (dones != 1 || acc != 160 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL backpressure_dump: dones %0d bytes %0d left %0d, required 1 160 0", dones, acc, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_regfile_write();
        int dones, acc;
        preload0();
        regs0[2] = 32'h22222222;
        regs0[3] = 32'h33333333;
        push_dump0();
        // r3 is rewritten before its LATCH cycle, so frame 3 carries the new value.
        exp_q[16] = 8'hCA; exp_q[17] = 8'hFE; exp_q[18] = 8'hF0; exp_q[19] = 8'h0D;
        run_dump0(100, 1'b1, -1, dones, acc);
        n_cmp++;
        if (dones != 1 || acc != 160 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL write_dump: dones %0d bytes %0d left %0d, required 1 160 0", dones, acc, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_dump();
        int dones, acc, late_done;
        logic [7:0] exp_b;
        preload0();
        push_dump0();
        run_dump0(100, 1'b0, 37, dones, acc);
        exp_b = (exp_q.size() != 0) ? exp_q[0] : 8'hxx;
        n_cmp++;
        if (bus0.out_valid !== 1'b1 || bus0.out_byte !== exp_b || bus0.rd_addr !== 5'd7) begin
            n_bad++;
            $display("FAIL frame7_byte2: valid %b byte %h addr %0d, required 1 %h 7",
                     bus0.out_valid, bus0.out_byte, bus0.rd_addr, exp_b);
        end
        #2 clrn = 1'b1;
        #1;
        n_cmp++;
        if ({busy0, done0, bus0.out_valid, bus0.out_byte, bus0.rd_addr} !== 16'd0) begin
            n_bad++;
            $display("FAIL async_reset: busy/done/valid/byte/addr = %h, required 0000",
                     {busy0, done0, bus0.out_valid, bus0.out_byte, bus0.rd_addr});
        end
        for (int i = 0; i < 32; i++) regs0[i] = 32'd0;
        @(negedge clk);
        clrn = 1'b0;
        late_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done0 || busy0 || bus0.out_valid) late_done++;
        end
        n_cmp++;
        if (late_done != 0) begin
            n_bad++;
            $display("FAIL no_resume: %0d active cycles after reset, required 0", late_done);
        end
        exp_q.delete();
        push_dump0();
        run_dump0(100, 1'b0, -1, dones, acc);
        n_cmp++;
        if (dones != 1 || acc != 160 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL zero_dump: dones %0d bytes %0d left %0d, required 1 160 0", dones, acc, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_start_held();
        int cyc_now, last_done, n_done;
        logic [7:0] exp_b;
        logic check_busy;
        regs1[5] = 32'h0F1E2D3C;
        for (int d = 0; d < 3; d++) begin
            exp_q.push_back(8'h05); exp_q.push_back(8'h3C); exp_q.push_back(8'h2D);
            exp_q.push_back(8'h1E); exp_q.push_back(8'h0F);
        end
        bus1.out_ready = 1'b1;
        @(posedge clk); #1 start1 = 1'b1;
        cyc_now = 0; last_done = -1; n_done = 0; check_busy = 1'b0;
        for (int i = 0; i < 200 && n_done < 3; i++) begin
            @(negedge clk);
            cyc_now++;
            if (check_busy) begin
                check_busy = 1'b0;
                n_cmp++;
                if (busy1 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL restart_after_done: busy %b, required 1", busy1);
                end
            end
            if (bus1.out_valid && bus1.out_ready) begin
                n_cmp++;
                exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                if (bus1.out_byte !== exp_b) begin
                    n_bad++;
                    $display("FAIL held_byte: got %h, required %h", bus1.out_byte, exp_b);
                end
            end
            if (done1) begin
                n_done++;
                // Accept edge to visible done is 7 edges; restart is the edge after.
                if (last_done >= 0) begin
                    n_cmp++;
                    if (cyc_now - last_done != 8) begin
                        n_bad++;
                        $display("FAIL done_period: %0d cycles, required 8", cyc_now - last_done);
                    end
                end
                last_done = cyc_now;
                if (n_done < 3) check_busy = 1'b1;
                else start1 = 1'b0;
            end
        end
        start1 = 1'b0;
        n_cmp++;
        if (n_done != 3 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL start_held: dones %0d left %0d, required 3 0", n_done, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        bus0.out_ready = 1'b0;
        bus1.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            regs0[i] = 32'd0;
            regs1[i] = 32'd0;
        end
        test_reset();
        test_full_dump();
        test_msb_lsb();
        test_backpressure();
        test_regfile_write();
        test_reset_mid_dump();
        test_start_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
